// File: rtl/fpu_pkg.sv
// Shared FPU types, constants and operand-decode helpers.
// FSUB_FTZ_EN (optional define) makes denormal operands decode as signed zero.
package fpu_pkg;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] man;
  } float_t;

  localparam logic [7:0]  EXP_MAX      = 8'd255;
  localparam logic [31:0] QNAN_DEFAULT = 32'hFFC0_0000;
  localparam logic [31:0] POS_INF      = 32'h7F80_0000;
  localparam logic [31:0] NEG_INF      = 32'hFF80_0000;
  localparam logic [31:0] QUIET_BIT    = 32'h0040_0000;

  typedef struct packed {
    logic        is_nan;
    logic        is_inf;
    logic        inf_sign;
    logic [31:0] nan_payload;
  } fflags_t;

  // Aligned operands: 24-bit significand followed by guard, round, sticky.
  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [26:0] m_l;
    logic [26:0] m_s;
    logic        op_sub;
    logic        zero_sign;
    fflags_t     flags;
  } align_t;

  typedef struct packed {
    logic        sign;
    logic [8:0]  exp;
    logic [26:0] mant;
    logic [4:0]  lz;
    logic        zero_sign;
    fflags_t     flags;
  } addsub_t;

  function automatic logic f_is_nan(input float_t f);
    return (f.exp == EXP_MAX) && (f.man != 23'd0);
  endfunction

  function automatic logic f_is_inf(input float_t f);
    return (f.exp == EXP_MAX) && (f.man == 23'd0);
  endfunction

  function automatic logic [7:0] f_eff_exp(input float_t f);
    return (f.exp == 8'd0) ? 8'd1 : f.exp;
  endfunction

  function automatic logic [23:0] f_sig(input float_t f);
`ifdef FSUB_FTZ_EN
    return (f.exp == 8'd0) ? 24'd0 : {1'b1, f.man};
`else
    return {f.exp != 8'd0, f.man};
`endif
  endfunction

endpackage

// File: rtl/fpu_lzc.sv
// Combinational leading-zero counter; an all-zero input returns W.
module fpu_lzc #(
  parameter int W  = 27,
  parameter int CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  d,
  output logic [CW-1:0] cnt
);

  // Highest set bit wins since it is visited last.
  always_comb begin
    cnt = CW'(W);
    for (int i = 0; i < W; i++)
      if (d[i]) cnt = CW'(W - 1 - i);
  end

endmodule

// File: rtl/fsub_pipe.sv
// Pipelined single-precision subtractor y = x1 - x2 with tag pass-through.
// Define FSUB_FTZ_EN for flush-to-zero on denormal inputs and tiny results.
module fsub_pipe
  import fpu_pkg::*;
#(
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      x1,
  input  logic [31:0]      x2,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      y,
  output logic             ovf,
  output logic [TAG_W-1:0] out_tag
);

  localparam int STAGES = 3;

  // Slot 0 holds the captured operands; slots 1..3 are the arithmetic stages.
  logic [STAGES:0]            vld_pipe;
  logic [STAGES:0][TAG_W-1:0] tag_pipe;
  logic                       en;

  assign en        = !vld_pipe[STAGES] || out_ready;
  assign in_ready  = en;
  assign out_valid = vld_pipe[STAGES];
  assign out_tag   = tag_pipe[STAGES];

  float_t  a_q, b_q;
  align_t  s1_d, s1_q;
  addsub_t s2_d, s2_q;
  logic [31:0] y_d, y_q;
  logic        ovf_d, ovf_q;

  assign y   = y_q;
  assign ovf = ovf_q;

  // ---------------- stage 1: unpack / align ----------------
  float_t      bn;
  logic        na, nb, ia, ib, a_ge;
  logic [7:0]  ea, eb, el, es, ediff;
  logic [23:0] ma, mb, ml, ms;
  logic        sl, ss;
  logic [4:0]  sh1;
  logic [49:0] ext;

  always_comb begin
    bn      = b_q;
    bn.sign = ~b_q.sign;
    na = f_is_nan(a_q);
    nb = f_is_nan(b_q);
    ia = f_is_inf(a_q);
    ib = f_is_inf(b_q);
    ea = f_eff_exp(a_q);
    eb = f_eff_exp(b_q);
    ma = f_sig(a_q);
    mb = f_sig(b_q);
    a_ge = {ea, ma} >= {eb, mb};
    {sl, el, ml} = a_ge ? {a_q.sign, ea, ma} : {bn.sign, eb, mb};
    {ss, es, ms} = a_ge ? {bn.sign, eb, mb} : {a_q.sign, ea, ma};
    ediff = el - es;
    sh1   = (ediff > 8'd31) ? 5'd31 : ediff[4:0];
    ext   = {ms, 26'd0} >> sh1;

    s1_d.sign      = sl;
    s1_d.exp       = el;
    s1_d.m_l       = {ml, 3'b000};
    s1_d.m_s       = {ext[49:24], |ext[23:0]};
    s1_d.op_sub    = sl ^ ss;
    s1_d.zero_sign = a_q.sign & bn.sign;

    s1_d.flags.is_nan      = 1'b0;
    s1_d.flags.is_inf      = 1'b0;
    s1_d.flags.inf_sign    = 1'b0;
    s1_d.flags.nan_payload = QNAN_DEFAULT;
    if (na) begin
      s1_d.flags.is_nan      = 1'b1;
      s1_d.flags.nan_payload = a_q | QUIET_BIT;
    end else if (nb) begin
      s1_d.flags.is_nan      = 1'b1;
      s1_d.flags.nan_payload = b_q | QUIET_BIT;
    end else if (ia && ib) begin
      // Same-signed infinities cancel under subtraction.
      if (a_q.sign == b_q.sign) s1_d.flags.is_nan = 1'b1;
      else begin
        s1_d.flags.is_inf   = 1'b1;
        s1_d.flags.inf_sign = a_q.sign;
      end
    end else if (ia) begin
      s1_d.flags.is_inf   = 1'b1;
      s1_d.flags.inf_sign = a_q.sign;
    end else if (ib) begin
      s1_d.flags.is_inf   = 1'b1;
      s1_d.flags.inf_sign = bn.sign;
    end
  end

  // ---------------- stage 2: add / sub + LZC ----------------
  logic [27:0] sum2;
  logic [26:0] norm2;
  logic [8:0]  exp2;
  logic [4:0]  lz2;

  always_comb begin
    sum2 = s1_q.op_sub ? ({1'b0, s1_q.m_l} - {1'b0, s1_q.m_s})
                       : ({1'b0, s1_q.m_l} + {1'b0, s1_q.m_s});
    if (sum2[27]) begin
      norm2 = {sum2[27:2], sum2[1] | sum2[0]};
      exp2  = {1'b0, s1_q.exp} + 9'd1;
    end else begin
      norm2 = sum2[26:0];
      exp2  = {1'b0, s1_q.exp};
    end
  end

  fpu_lzc #(.W(27)) u_lzc (.d(norm2), .cnt(lz2));

  always_comb begin
    s2_d.sign      = s1_q.sign;
    s2_d.exp       = exp2;
    s2_d.mant      = norm2;
    s2_d.lz        = lz2;
    s2_d.zero_sign = s1_q.zero_sign;
    s2_d.flags     = s1_q.flags;
  end

  // ---------------- stage 3: normalize / round ----------------
  logic [4:0]  sh3;
  logic [8:0]  e_new;
  logic [26:0] m3;
  logic        rnd, tiny;
  logic [24:0] mr;
  logic [9:0]  e_fin;
  logic [22:0] man_fin;

  always_comb begin
    tiny = 1'b0;
`ifdef FSUB_FTZ_EN
    tiny  = s2_q.exp <= {4'd0, s2_q.lz};
    sh3   = s2_q.lz;
    e_new = s2_q.exp - {4'd0, s2_q.lz};
`else
    // Clamp the shift so the exponent bottoms out at the denormal encoding.
    if (s2_q.exp > {4'd0, s2_q.lz}) begin
      sh3   = s2_q.lz;
      e_new = s2_q.exp - {4'd0, s2_q.lz};
    end else begin
      sh3   = s2_q.exp[4:0] - 5'd1;
      e_new = 9'd0;
    end
`endif
    m3  = s2_q.mant << sh3;
    rnd = m3[2] & (m3[1] | m3[0] | m3[3]);
    mr  = {1'b0, m3[26:3]} + {24'd0, rnd};
    // A denormal that rounds up into bit 23 becomes the smallest normal.
    e_fin   = (e_new == 9'd0) ? {9'd0, mr[23]} : ({1'b0, e_new} + {9'd0, mr[24]});
    man_fin = mr[24] ? mr[23:1] : mr[22:0];

    ovf_d = 1'b0;
    if (s2_q.flags.is_nan)      y_d = s2_q.flags.nan_payload;
    else if (s2_q.flags.is_inf) y_d = s2_q.flags.inf_sign ? NEG_INF : POS_INF;
    else if (s2_q.lz == 5'd27)  y_d = {s2_q.zero_sign, 31'd0};
    else if (tiny)              y_d = {s2_q.sign, 31'd0};
    else if (e_fin >= 10'd255) begin
      y_d   = s2_q.sign ? NEG_INF : POS_INF;
      ovf_d = 1'b1;
    end else                    y_d = {s2_q.sign, e_fin[7:0], man_fin};
  end

  // ---------------- registers ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      tag_pipe <= '0;
      y_q      <= '0;
      ovf_q    <= 1'b0;
    end else if (en) begin
      vld_pipe <= {vld_pipe[STAGES-1:0], in_valid};
      tag_pipe <= {tag_pipe[STAGES-1:0], in_tag};
      if (vld_pipe[STAGES-1]) begin
        y_q   <= y_d;
        ovf_q <= ovf_d;
      end
    end
  end

  // Data slots carry no reset; bubbles may leave stale contents.
  always_ff @(posedge clk) begin
    if (en) begin
      a_q  <= x1;
      b_q  <= x2;
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

endmodule

// File: tb/tb_fsub_pipe.sv
// Randomized self-checking bench for fsub_pipe against an exact-integer model.
module tb_fsub_pipe;

  localparam int TAG_W = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid, in_ready, out_valid, out_ready, ovf;
  logic [31:0]      x1, x2, y;
  logic [TAG_W-1:0] in_tag, out_tag;

  fsub_pipe #(.TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .x1(x1), .x2(x2), .in_tag(in_tag), .out_valid(out_valid),
    .out_ready(out_ready), .y(y), .ovf(ovf), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [32:0]      e;
    logic [TAG_W-1:0] tag;
    int               acc;
    bit               lat;
  } sb_t;

  sb_t  sb[$];
  int   checks = 0, errors = 0, cyc = 0;
  bit   stalled = 0;
  logic [31:0] snap_y;
  logic        snap_ovf;
  logic [TAG_W-1:0] snap_tag;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Operand magnitude as an exact integer in units of 2^-149.
  function automatic logic [299:0] mag_of(input logic [31:0] f);
    logic [299:0] v;
    v = '0;
    if (f[30:23] == 8'd0) begin
`ifndef FSUB_FTZ_EN
      v[22:0] = f[22:0];
`endif
    end else begin
      v[23:0] = {1'b1, f[22:0]};
      v = v << (f[30:23] - 8'd1);
    end
    return v;
  endfunction

  // Returns {ovf, y} for a - b.
  function automatic logic [32:0] ref_sub(input logic [31:0] a, input logic [31:0] b);
    logic [299:0] va, vb, mag, q, rem, half;
    logic sa, sb_, s, na, nb, ia, ib;
    int p, sh, be;
    na = (a[30:23] == 8'hFF) && (a[22:0] != 0);
    nb = (b[30:23] == 8'hFF) && (b[22:0] != 0);
    ia = (a[30:23] == 8'hFF) && (a[22:0] == 0);
    ib = (b[30:23] == 8'hFF) && (b[22:0] == 0);
    if (na) return {1'b0, a | 32'h0040_0000};
    if (nb) return {1'b0, b | 32'h0040_0000};
    if (ia && ib) return {1'b0, (a[31] == b[31]) ? 32'hFFC0_0000 : {a[31], 31'h7F80_0000}};
    if (ia) return {1'b0, a};
    if (ib) return {1'b0, ~b[31], b[30:0]};
    va = mag_of(a); vb = mag_of(b);
    sa = a[31]; sb_ = ~b[31];
    if (sa == sb_)     begin mag = va + vb; s = sa;  end
    else if (va >= vb) begin mag = va - vb; s = sa;  end
    else               begin mag = vb - va; s = sb_; end
    if (mag == '0) return {1'b0, sa & sb_, 31'd0};
    p = 0;
    for (int i = 0; i < 300; i++) if (mag[i]) p = i;
`ifdef FSUB_FTZ_EN
    if (p < 23) return {1'b0, s, 31'd0};
`endif
    if (p <= 23) return {1'b0, s, mag[30:0]};
    sh   = p - 23;
    q    = mag >> sh;
    rem  = mag & ((300'd1 << sh) - 300'd1);
    half = 300'd1 << (sh - 1);
    if (rem > half || (rem == half && q[0])) q = q + 300'd1;
    if (q[24]) begin q = q >> 1; sh++; end
    be = sh + 1;
    if (be >= 255) return {1'b1, s, 8'hFF, 23'd0};
    return {1'b0, s, 8'(be), q[22:0]};
  endfunction

  function automatic logic [31:0] rnd_op(input logic [31:0] r);
    logic [31:0] v;
    int e;
    v = $urandom;
    case ($urandom_range(0, 9))
      0: ;
      1: case ($urandom_range(0, 5))
           0: v = 32'h0000_0000;
           1: v = 32'h8000_0000;
           2: v = 32'h7F80_0000;
           3: v = 32'hFF80_0000;
           4: v = {v[31], 8'hFF, v[22:0] | 23'h1};
           default: v = {v[31], 31'h7F7F_FFFF};
         endcase
      2: v[30:23] = 8'h00;
      3: v = r ^ {v[31], 31'd0};
      default: begin
        e = int'(r[30:23]) + int'($urandom_range(0, 6)) - 3;
        if (e < 0) e = 0;
        if (e > 254) e = 254;
        v[30:23] = 8'(e);
      end
    endcase
    return v;
  endfunction

  // One clock: drive at negedge, check outputs, record the coming transfers.
  task automatic cycle(input logic iv, input logic [31:0] a, input logic [31:0] b,
                       input logic [TAG_W-1:0] t, input logic ordy,
                       input logic [32:0] e, input bit lat, output bit acc);
    sb_t ent;
    @(negedge clk);
    in_valid = iv; x1 = a; x2 = b; in_tag = t; out_ready = ordy;
    #1;
    cyc++;
    acc = 0;
    if (rst) begin
      stalled = 0;
      return;
    end
    if (stalled) begin
      chk("hold_y", y, snap_y);
      chk("hold_ovf", ovf, snap_ovf);
      chk("hold_tag", out_tag, snap_tag);
      chk("hold_valid", out_valid, 1);
    end
    if (out_valid && !out_ready) chk("stall_in_ready", in_ready, 0);
    if (out_valid && out_ready) begin
      if (sb.size() == 0) chk("spurious_out", out_valid, 0);
      else begin
        ent = sb.pop_front();
        chk("y", y, ent.e[31:0]);
        chk("ovf", ovf, ent.e[32]);
        chk("tag", out_tag, ent.tag);
        if (ent.lat) chk("latency", cyc - ent.acc, 4);
      end
    end
    if (in_valid && in_ready) begin
      sb.push_back('{e: e, tag: t, acc: cyc, lat: lat});
      acc = 1;
    end
    stalled  = out_valid && !out_ready;
    snap_y   = y;
    snap_ovf = ovf;
    snap_tag = out_tag;
  endtask

  task automatic idle(input logic ordy);
    bit acc;
    cycle(1'b0, 32'd0, 32'd0, '0, ordy, 33'd0, 1'b0, acc);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && sb.size() != 0; i++) idle(1'b1);
    chk("drain_empty", sb.size(), 0);
    for (int i = 0; i < 5; i++) idle(1'b1);
  endtask

  localparam int ND = 10;
  logic [31:0] d_a [ND] = '{32'h4040_0000, 32'h3F80_0000, 32'h8000_0000, 32'h7F7F_FFFF,
                            32'h7F80_0000, 32'h4B80_0001, 32'h0080_0000, 32'h7FA0_0000,
                            32'h3F80_0000, 32'h3F80_0000};
  logic [31:0] d_b [ND] = '{32'h3F80_0000, 32'h3F80_0000, 32'h0000_0000, 32'hFF7F_FFFF,
                            32'h7F80_0000, 32'h3F80_0000, 32'h0000_0001, 32'h7F80_0001,
                            32'hFF80_0001, 32'h7F80_0000};
  logic [32:0] d_e [ND] = '{{1'b0, 32'h4000_0000}, {1'b0, 32'h0000_0000}, {1'b0, 32'h8000_0000},
                            {1'b1, 32'h7F80_0000}, {1'b0, 32'hFFC0_0000}, {1'b0, 32'h4B80_0000},
`ifdef FSUB_FTZ_EN
                            {1'b0, 32'h0080_0000},
`else
                            {1'b0, 32'h007F_FFFF},
`endif
                            {1'b0, 32'h7FE0_0000}, {1'b0, 32'hFFC0_0001}, {1'b0, 32'hFF80_0000}};

  initial begin
    bit acc;
    int n, k;
    logic [31:0] a, b;
    rst = 1; in_valid = 0; x1 = 0; x2 = 0; in_tag = 0; out_ready = 1;
    repeat (3) idle(1'b1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_y", y, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_tag", out_tag, 0);
    rst = 0;

    // Directed vectors, back to back.
    for (int i = 0; i < ND; i++)
      cycle(1'b1, d_a[i], d_b[i], TAG_W'(i + 7), 1'b1, d_e[i], 1'b1, acc);
    drain();

    // Backpressure: six ops, tags 0..5, out_ready low for four stalled cycles.
    n = 0; k = 0;
    while (n < 6 && k < 40) begin
      a = rnd_op($urandom); b = rnd_op(a);
      cycle(1'b1, a, b, TAG_W'(n), !(k >= 5 && k < 9), ref_sub(a, b), 1'b0, acc);
      if (acc) n++;
      k++;
    end
    chk("bp_sent", n, 6);
    for (int i = 0; i < 6; i++) idle(!(k + i >= 5 && k + i < 9));
    drain();

    // Reset with two ops in flight: they must never appear.
    a = 32'h4040_0000; b = 32'h3F80_0000;
    cycle(1'b1, a, b, 5'd20, 1'b1, ref_sub(a, b), 1'b1, acc);
    cycle(1'b1, b, a, 5'd21, 1'b1, ref_sub(b, a), 1'b1, acc);
    rst = 1;
    idle(1'b1);
    rst = 0;
    sb.delete();
    idle(1'b1);
    chk("rst_flush_valid", out_valid, 0);
    cycle(1'b1, 32'h4120_0000, 32'h3F80_0000, 5'd22, 1'b1, {1'b0, 32'h4110_0000}, 1'b1, acc);
    drain();

    // Free-flowing random traffic: latency is fixed at three edges after capture.
    n = 0;
    for (int i = 0; i < 200 && n < 40; i++) begin
      a = rnd_op($urandom); b = rnd_op(a);
      cycle(1'($urandom_range(0, 3) != 0), a, b, TAG_W'($urandom), 1'b1, ref_sub(a, b), 1'b1, acc);
      if (acc) n++;
    end
    drain();

    // Random traffic with random backpressure.
    n = 0;
    for (int i = 0; i < 1500 && n < 300; i++) begin
      a = rnd_op($urandom); b = rnd_op(a);
      cycle(1'($urandom_range(0, 4) != 0), a, b, TAG_W'($urandom),
            1'($urandom_range(0, 3) != 0), ref_sub(a, b), 1'b0, acc);
      if (acc) n++;
    end
    chk("rand_sent", n, 300);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fsub_pipe.md
Name: fsub_pipe

Overview:
Pipelined IEEE-754 single-precision subtractor computing y = x1 - x2 for the FPU's subtract path. It is the inverse-operation partner of the combinational adder.
- 3-stage pipeline with valid/ready handshakes on both sides.
- Carries an opaque tag (destination register id) alongside each operation.
- Sits between the issue unit and the FPU writeback arbiter.

Parameters:
TAG_W, 5, width of the tag passed through unchanged with each operation.

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous active-high reset
in_valid  in  1  operation offered
in_ready  out  1  block accepts the operation this cycle
x1  in  32  minuend
x2  in  32  subtrahend
in_tag  in  TAG_W  tag for this operation
out_valid  out  1  result available
out_ready  in  1  consumer accepts the result this cycle
y  out  32  x1 - x2
ovf  out  1  finite operands produced an infinite result
out_tag  out  TAG_W  tag of the result

Behaviour:
- Pipeline enable:
  - en = !out_valid || out_ready; in_ready = en.
  - Every stage register, including its valid bit, advances only when en = 1.
  - A transfer occurs when in_valid && in_ready, or when out_valid && out_ready.
- Latency: a transfer accepted at edge N gives out_valid = 1 after edge N+3, provided en stays 1. Throughput is 1 op/cycle.
- Stage 1, unpack/align:
  - Negate the sign of x2.
  - Hidden bit is 1 for exp != 0. Denormals use effective exponent 1.
  - Select the larger-magnitude operand. Ties are broken on mantissa.
  - Right-shift the smaller mantissa by the exponent difference, saturating at 31. Keep guard, round and sticky bits.
- Stage 2, add/sub:
  - Compute the 27-bit mantissa sum or difference.
  - Count leading zeros with fpu_lzc.
- Stage 3, normalize/round:
  - Normalize, clamping the exponent so underflow yields a denormal.
  - Round to nearest even. Renormalize on mantissa carry-out.
  - Apply special-case overrides.
- Special cases, decided in stage 1 and carried as flags:
  - NaN operand -> that NaN quieted (bit 22 forced to 1). x1's NaN takes priority.
  - inf - inf, same sign -> 0xFFC00000.
  - Single infinity -> that infinity with its effective sign.
  - Exact zero result -> +0, except (-0) - (+0) -> 0x80000000.
- ovf: set when both operands are finite and the result exponent reaches 255. y is then ±inf (0x7F800000 / 0xFF800000). ovf is 0 for all special-case results.
- Stall: while out_valid && !out_ready, y, ovf and out_tag hold stable and no input is accepted.
- Reset:
  - All stage valid bits clear; out_valid = 0, in_ready = 1.
  - y = 0, ovf = 0, out_tag = 0.
  - Reset asserted mid-operation discards all in-flight operations. No output appears for them.
- Bubbles propagate as invalid stage slots; a slot's data registers may hold stale values.

Optional Feature:
FSUB_FTZ_EN
- Defined: denormal inputs are treated as signed zero. Results below the normal range are flushed to signed zero, with the sign of the exact result. The stage-3 denormal shift path is removed.
- Undefined: full gradual-underflow support as described in Behaviour.

Decomposition:
- Shared package fpu_pkg:
  - typedef float_t, packed as sign, exp[7:0], man[22:0].
  - Constants EXP_MAX = 8'd255, QNAN_DEFAULT = 32'hFFC00000, POS_INF, NEG_INF.
  - Stage-flag struct: is_nan, is_inf, inf_sign, nan_payload.
- Sub-module fpu_lzc: 27-bit combinational leading-zero counter, returning 0..27. It is reusable by the other FPU units.

Test Plan:
- 0x40400000 - 0x3F800000 (3 - 1), out_ready = 1 -> y = 0x40000000, ovf = 0, out_valid 3 cycles after accept, tag preserved.
- 0x3F800000 - 0x3F800000 -> 0x00000000; 0x80000000 - 0x00000000 -> 0x80000000.
- 0x7F7FFFFF - 0xFF7FFFFF -> 0x7F800000, ovf = 1. Separately, 0x7F800000 - 0x7F800000 -> 0xFFC00000, ovf = 0.
- Tie rounding: 0x4B800001 - 0x3F800000 -> 0x4B800000 (even). Denormal: 0x00800000 - 0x00000001 -> 0x007FFFFF. With FSUB_FTZ_EN the denormal case gives 0x00800000.
- Backpressure: 6 back-to-back ops with tags 0..5, out_ready low for 4 cycles mid-stream -> in_ready low during the stall, outputs stable, all 6 results delivered in order, none lost or duplicated.
- Reset asserted for 1 cycle with 2 ops in flight -> out_valid = 0 next cycle, those ops never appear, a new op afterwards completes with 3-cycle latency.
